// File: rtl/fib_result_monitor.sv
// Passive write-back checker: rebuilds the Fibonacci sequence from two seed loads and
// verifies each computed ALU result, reporting progress, overflow termination or first error.
module fib_result_monitor #(
  parameter logic [7:0]  ADD_OP    = 8'h05,
  parameter int unsigned CARRY_BIT = 0,
  parameter int unsigned COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mon_en,
  input  logic [7:0]         alu_op,
  input  logic               immediate_p,
  input  logic [2:0]         dest_reg,
  input  logic [15:0]        alu_bus,
  input  logic [4:0]         flags,
  output logic [COUNT_W-1:0] term_count,
  output logic [15:0]        last_term,
  output logic [2:0]         last_dest,
  output logic               done,
  output logic               fail,
  output logic [1:0]         err_code,
  output logic [15:0]        fail_expected,
  output logic [15:0]        fail_got
);

  localparam logic [2:0] StSeedA = 3'd0;
  localparam logic [2:0] StSeedB = 3'd1;
  localparam logic [2:0] StCheck = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StFail  = 3'd4;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrValue   = 2'd1;
  localparam logic [1:0] ErrOrder   = 2'd2;
  localparam logic [1:0] ErrReseed  = 2'd3;

  logic [2:0]         state_q, state_d;
  logic [15:0]        exp_prev_q, exp_prev_d;
  logic [15:0]        exp_cur_q, exp_cur_d;
  logic [COUNT_W-1:0] term_count_q, term_count_d;
  logic [15:0]        last_term_q, last_term_d;
  logic [2:0]         last_dest_q, last_dest_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [15:0]        fail_expected_q, fail_expected_d;
  logic [15:0]        fail_got_q, fail_got_d;

  logic        add_ev;
  logic        seed_ev;
  logic        comp_ev;
  logic [16:0] sum;
  logic        carry;

  assign add_ev  = mon_en && (alu_op == ADD_OP);
  assign seed_ev = add_ev && immediate_p;
  assign comp_ev = add_ev && !immediate_p;
  assign sum     = {1'b0, exp_prev_q} + {1'b0, exp_cur_q};
  assign carry   = flags[CARRY_BIT];

  always_comb begin
    state_d         = state_q;
    exp_prev_d      = exp_prev_q;
    exp_cur_d       = exp_cur_q;
    term_count_d    = term_count_q;
    last_term_d     = last_term_q;
    last_dest_d     = last_dest_q;
    err_code_d      = err_code_q;
    fail_expected_d = fail_expected_q;
    fail_got_d      = fail_got_q;

    case (state_q)
      StSeedA, StSeedB: begin
        if (seed_ev) begin
          if (state_q == StSeedA) begin
            exp_prev_d = alu_bus;
            state_d    = StSeedB;
          end else begin
            exp_cur_d = alu_bus;
            state_d   = StCheck;
          end
          last_term_d = alu_bus;
          last_dest_d = dest_reg;
        end else if (comp_ev) begin
          state_d         = StFail;
          err_code_d      = ErrOrder;
          fail_expected_d = 16'h0000;
          fail_got_d      = alu_bus;
        end
      end
      StCheck: begin
        if (comp_ev) begin
          if (sum[16] && carry) begin
            state_d = StDone;
          end else if (!sum[16] && !carry && (alu_bus == sum[15:0])) begin
            exp_prev_d  = exp_cur_q;
            exp_cur_d   = alu_bus;
            last_term_d = alu_bus;
            last_dest_d = dest_reg;
            if (term_count_q != '1) begin
              term_count_d = term_count_q + 1'b1;
            end
          end else begin
            state_d         = StFail;
            err_code_d      = ErrValue;
            fail_expected_d = sum[15:0];
            fail_got_d      = alu_bus;
          end
        end else if (seed_ev) begin
          state_d         = StFail;
          err_code_d      = ErrReseed;
          fail_expected_d = exp_cur_q;
          fail_got_d      = alu_bus;
        end
      end
      default: ;  // done / fail are terminal until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StSeedA;
      exp_prev_q      <= '0;
      exp_cur_q       <= '0;
      term_count_q    <= '0;
      last_term_q     <= '0;
      last_dest_q     <= '0;
      err_code_q      <= ErrNone;
      fail_expected_q <= '0;
      fail_got_q      <= '0;
    end else begin
      state_q         <= state_d;
      exp_prev_q      <= exp_prev_d;
      exp_cur_q       <= exp_cur_d;
      term_count_q    <= term_count_d;
      last_term_q     <= last_term_d;
      last_dest_q     <= last_dest_d;
      err_code_q      <= err_code_d;
      fail_expected_q <= fail_expected_d;
      fail_got_q      <= fail_got_d;
    end
  end

  assign term_count    = term_count_q;
  assign last_term     = last_term_q;
  assign last_dest     = last_dest_q;
  assign done          = (state_q == StDone);
  assign fail          = (state_q == StFail);
  assign err_code      = err_code_q;
  assign fail_expected = fail_expected_q;
  assign fail_got      = fail_got_q;

endmodule
